mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the processor's single-port instruction/data memory (12-bit words, 10-bit address) between three requesters: instruction fetch (IF), data access (EX/MEM) and the external program loader.
- Sits between the pipeline stages and the memory array.
- Issues at most one memory access per cycle.
- Returns read data one cycle after grant.
- Enforces loader ownership and fetch anti-starvation.

Parameters:
- AW, 10, memory address width (matches PC width)
- DW, 12, memory word width
- MAX_WAIT, 3, consecutive cycles fetch may lose arbitration before it is forced to win

Ports:
- clk1  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch address (PC)
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch read data valid on rdata
- dm_req  in  1  data request
- dm_we  in  1  data write enable
- dm_addr  in  AW  data address
- dm_wdata  in  DW  data write value
- dm_gnt  out  1  data granted this cycle
- dm_rvalid  out  1  data read data valid on rdata
- ld_req  in  1  loader request; holding it high keeps ownership
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write value (loader writes only)
- ld_gnt  out  1  loader granted this cycle
- halted  in  1  processor HALTED flag; blocks fetch grants
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0
- rdata  out  DW  registered copy of mem_rdata
- busy  out  1  high while FSM is in LOAD

Behaviour:
- Reset: all gnt, rvalid, mem_en, mem_we, busy outputs are 0; mem_addr, mem_wdata and rdata are 0; FSM = RUN; starve counter = 0.
- Grants are combinational from the current requests and state; mem_* outputs are driven combinationally in the grant cycle.
- Exactly one, or no, gnt is high per cycle; mem_en = OR of the gnts.
- FSM RUN, priority: ld_req > forced fetch > dm_req > if_req.
  - Fetch is forced when starve == MAX_WAIT and if_req is high and halted is low.
- FSM transitions:
  - RUN -> LOAD: when ld_gnt is issued.
  - LOAD -> RUN: on the first cycle ld_req is low; that cycle already arbitrates as RUN, so there is no dead cycle.
- FSM LOAD: only ld_req can be granted; if_req and dm_req stall (gnt = 0); busy = 1.
- Starve counter:
  - Increments (saturating at MAX_WAIT) on each RUN cycle where if_req=1, halted=0 and if_gnt=0.
  - Clears on if_gnt, or when if_req=0.
  - Held in LOAD.
- halted=1: if_gnt is never asserted and the starve counter clears; data and loader accesses proceed.
- Reads:
  - A read grant at cycle N gives rvalid for that requester at N+1, with rdata = mem_rdata captured at the end of N+1 and held until the next read completes.
  - Back-to-back reads are permitted every cycle.
  - A write grant produces no rvalid.
- Requesters hold req, addr and wdata stable until they see gnt high; the arbiter does not queue requests.
- Reset mid-operation: any pending rvalid is dropped (no rvalid after reset release); ownership returns to RUN.
- Simultaneous ld_req rise and a pending read rvalid: the rvalid still issues at N+1.

Decomposition:
- Shared package (proc_pkg) holds:
  - AW/DW defaults
  - FSM state encoding (RUN=0, LOAD=1)
  - requester index constants (REQ_IF, REQ_DM, REQ_LD)
- Natural sub-module: starve_counter (saturating counter with inc/clr/hold and a sat flag).

Test Plan:
- Reset, then if_req=1 with if_addr=5 for one cycle -> if_gnt=1, mem_addr=5, mem_we=0; next cycle if_rvalid=1 and rdata=memory[5].
- if_req and dm_req both held high, with dm_we=1, dm_addr=0x80 and dm_wdata=0x2A:
  - Cycles 1-3: dm_gnt=1.
  - Cycle 4: if_gnt=1 (forced).
  - Cycle 5: dm_gnt=1 again.
- ld_req high for 4 cycles writing addresses 0-3 with values 0x280/0x181/0x782/0x788, while if_req and dm_req are high:
  - ld_gnt=1 and busy=1 for 4 cycles; if_gnt=dm_gnt=0 throughout.
  - Cycle 5: busy=0 and dm_gnt=1.
- halted=1 with if_req=1 for 10 cycles -> if_gnt=0 throughout, starve counter stays 0; a concurrent dm read at 0x10 is granted with dm_rvalid the next cycle.
- Read granted at cycle N, reset asserted at N+1 -> if_rvalid=0, all outputs at reset values, no rvalid after reset deasserts.
- Alternating dm read 0x01, dm read 0x02 on consecutive cycles -> dm_rvalid high two consecutive cycles, with rdata=memory[1] then memory[2].

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and types for the processor memory arbiter: default widths,
// arbiter FSM encoding and requester indices.
package proc_pkg;

  localparam int unsigned AW_DEF       = 10;
  localparam int unsigned DW_DEF       = 12;
  localparam int unsigned MAX_WAIT_DEF = 3;

  typedef enum logic {
    StRun  = 1'b0,
    StLoad = 1'b1
  } arb_state_e;

  localparam int unsigned REQ_IF  = 0;
  localparam int unsigned REQ_DM  = 1;
  localparam int unsigned REQ_LD  = 2;
  localparam int unsigned NUM_REQ = 3;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive cycles fetch has lost arbitration.
// Clear has priority over increment; neither input asserted holds the count.
module starve_counter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic clk1,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;

  assign sat = (cnt_q == CW'(MAX_WAIT));

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch, data access and the
// program loader, with loader ownership and fetch anti-starvation.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic          halted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt;
  logic                 in_load;
  logic                 if_ok;
  logic                 starve_sat;
  logic                 if_rvalid_q, dm_rvalid_q;
  logic [DW-1:0]        rdata_q;

  assign if_ok = if_req && !halted;

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    in_load = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ld_req) begin
          state_d = StLoad;
          in_load = 1'b1;
        end
      end
      StLoad: begin
        // Dropping ld_req releases ownership in the same cycle.
        if (ld_req) begin
          in_load = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if (in_load) begin
      gnt[REQ_LD] = 1'b1;
    end else if (if_ok && starve_sat) begin
      gnt[REQ_IF] = 1'b1;
    end else if (dm_req) begin
      gnt[REQ_DM] = 1'b1;
    end else if (if_ok) begin
      gnt[REQ_IF] = 1'b1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[REQ_LD]) begin
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (gnt[REQ_DM]) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_we ? dm_wdata : '0;
    end else if (gnt[REQ_IF]) begin
      mem_addr  = if_addr;
    end
  end

  assign if_gnt    = gnt[REQ_IF];
  assign dm_gnt    = gnt[REQ_DM];
  assign ld_gnt    = gnt[REQ_LD];
  assign mem_en    = |gnt;
  assign busy      = in_load;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  // Memory data is live in the rvalid cycle; the register holds it afterwards.
  assign rdata     = (if_rvalid_q || dm_rvalid_q) ? mem_rdata : rdata_q;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk1  (clk1),
    .reset (reset),
    .inc   (!in_load && if_ok && !gnt[REQ_IF]),
    .clr   (!in_load && (!if_ok || gnt[REQ_IF])),
    .sat   (starve_sat)
  );

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= gnt[REQ_IF];
      dm_rvalid_q <= gnt[REQ_DM] && !dm_we;
      if (if_rvalid_q || dm_rvalid_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a synchronous memory, a per-cycle
// behavioural model checked on every falling edge, and literal spot checks.
module tb_mem_port_arbiter;

  localparam int unsigned AW       = 10;
  localparam int unsigned DW       = 12;
  localparam int unsigned MAX_WAIT = 3;

  logic          clk1 = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt;
  logic          halted = 1'b0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] rdata;
  logic          busy;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk1      (clk1),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .halted    (halted),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .busy      (busy)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 7 + 3);
  endfunction

  // Memory array attached to the arbiter.
  logic [DW-1:0] sram [1 << AW];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: memory image, pending read, held data, starve count.
  logic [DW-1:0] ref_mem [1 << AW];
  int            m_starve = 0;
  bit            m_pif = 0, m_pdm = 0;
  logic [DW-1:0] m_pval = '0, m_held = '0;

  always @(negedge clk1) begin
    int            g;  // 0 none, 1 fetch, 2 data, 3 loader
    bit            ok_if;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    if (reset) begin
      m_starve = 0; m_pif = 0; m_pdm = 0; m_held = '0;
      g = 0; e_we = 0; e_addr = '0; e_wd = '0; e_rd = '0;
    end else begin
      ok_if = if_req && !halted;
      if (ld_req)                            g = 3;
      else if (ok_if && m_starve >= MAX_WAIT) g = 1;
      else if (dm_req)                        g = 2;
      else if (ok_if)                         g = 1;
      else                                    g = 0;
      e_we = 0; e_addr = '0; e_wd = '0;
      case (g)
        1: e_addr = if_addr;
        2: begin e_addr = dm_addr; e_we = dm_we; e_wd = dm_we ? dm_wdata : '0; end
        3: begin e_addr = ld_addr; e_we = 1; e_wd = ld_wdata; end
        default: ;
      endcase
      e_rd = (m_pif || m_pdm) ? m_pval : m_held;
    end
    chk("if_gnt",    if_gnt,    g == 1);
    chk("dm_gnt",    dm_gnt,    g == 2);
    chk("ld_gnt",    ld_gnt,    g == 3);
    chk("mem_en",    mem_en,    g != 0);
    chk("mem_we",    mem_we,    e_we);
    chk("mem_addr",  mem_addr,  e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("busy",      busy,      g == 3);
    chk("if_rvalid", if_rvalid, m_pif);
    chk("dm_rvalid", dm_rvalid, m_pdm);
    chk("rdata",     rdata,     e_rd);
    if (!reset) begin
      if (m_pif || m_pdm) m_held = m_pval;
      m_pif = (g == 1);
      m_pdm = (g == 2) && !dm_we;
      if (g == 1) m_pval = ref_mem[if_addr];
      if (g == 2 && !dm_we) m_pval = ref_mem[dm_addr];
      if (g == 2 && dm_we) ref_mem[dm_addr] = dm_wdata;
      if (g == 3) ref_mem[ld_addr] = ld_wdata;
      if (g != 3) begin
        if (ok_if && g != 1) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
        else                 m_starve = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic settle();
    @(negedge clk1);
  endtask

  task automatic idle();
    if_req = 0; dm_req = 0; dm_we = 0; ld_req = 0; halted = 0;
  endtask

  initial begin
    logic [DW-1:0] lvals [4];
    lvals = '{12'h280, 12'h181, 12'h782, 12'h788};
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (2) tick();
    settle();
    chk("reset_busy", busy, 0);
    chk("reset_rdata", rdata, 0);
    tick();
    reset = 0;
    tick();

    // Single fetch at address 5.
    if_req = 1; if_addr = 10'd5;
    settle();
    chk("fetch_gnt", if_gnt, 1);
    chk("fetch_addr", mem_addr, 5);
    chk("fetch_we", mem_we, 0);
    tick();
    if_req = 0;
    settle();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", rdata, 12'h026);
    tick();

    // Data writes hog the port; fetch is forced on the fourth cycle.
    if_req = 1; if_addr = 10'd7;
    dm_req = 1; dm_we = 1; dm_addr = 10'h80; dm_wdata = 12'h02A;
    for (int k = 1; k <= 5; k++) begin
      settle();
      chk("starve_dm", dm_gnt, k != 4);
      chk("starve_if", if_gnt, k == 4);
      tick();
    end
    idle();
    tick();

    // Loader owns the port for four cycles, then releases with no dead cycle.
    if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 10'h20;
    ld_req = 1;
    for (int k = 0; k < 4; k++) begin
      ld_addr = AW'(k); ld_wdata = lvals[k];
      settle();
      chk("load_gnt", ld_gnt, 1);
      chk("load_busy", busy, 1);
      chk("load_stall", {if_gnt, dm_gnt}, 0);
      tick();
    end
    ld_req = 0;
    settle();
    chk("load_release_busy", busy, 0);
    chk("load_release_dm", dm_gnt, 1);
    tick();
    idle();
    tick();

    // Halted blocks fetch; a data read still completes.
    halted = 1; if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 10'h10;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("halt_no_fetch", if_gnt, 0);
      if (k == 1) begin
        chk("halt_dm_rvalid", dm_rvalid, 1);
        chk("halt_dm_rdata", rdata, 12'h073);
      end
      tick();
      dm_req = 0;
    end
    halted = 0; dm_req = 1;
    settle();
    chk("halt_starve_clear", dm_gnt, 1);
    tick();
    idle();
    tick();

    // Reset lands on the rvalid cycle of a fetch.
    if_req = 1; if_addr = 10'd9;
    settle();
    chk("rst_fetch_gnt", if_gnt, 1);
    tick();
    reset = 1; if_req = 0;
    settle();
    chk("rst_rvalid", if_rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    tick();
    reset = 0;
    settle();
    chk("rst_no_rvalid", {if_rvalid, dm_rvalid}, 0);
    tick();

    // Back-to-back data reads of loader-written words.
    dm_req = 1; dm_we = 0; dm_addr = 10'h01;
    tick();
    dm_addr = 10'h02;
    settle();
    chk("b2b_rvalid1", dm_rvalid, 1);
    chk("b2b_rdata1", rdata, 12'h181);
    tick();
    dm_req = 0;
    settle();
    chk("b2b_rvalid2", dm_rvalid, 1);
    chk("b2b_rdata2", rdata, 12'h782);
    tick();
    settle();
    chk("b2b_hold", rdata, 12'h782);
    tick();

    // Loader request rises while a read response is pending.
    dm_req = 1; dm_addr = 10'h03;
    tick();
    dm_req = 0; ld_req = 1; ld_addr = 10'h04; ld_wdata = 12'h555;
    settle();
    chk("ld_pend_rvalid", dm_rvalid, 1);
    chk("ld_pend_rdata", rdata, 12'h788);
    chk("ld_pend_gnt", ld_gnt, 1);
    tick();
    idle();
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
